// File: rtl/parity_engine.sv
// ============================================================================
// parity_engine: registered parity generator plus independent serial checker.
// Optional saturating mismatch counter: define PARITY_ERR_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module parity_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic [1:0]            PAR_TYP,
  output logic                  par_bit,
  input  logic                  rx_start,
  input  logic                  rx_bit,
  input  logic                  rx_bit_vld,
  input  logic                  rx_par_vld,
  output logic                  chk_busy,
  output logic                  par_err,
  input  logic                  err_clr,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCUM    = 2'd1;
  localparam logic [1:0] WAIT_PAR = 2'd2;

  localparam logic [1:0] MODE_EVEN = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_MARK = 2'b10;

  function automatic logic parity_of(input logic [1:0] pmode, input logic xr);
    case (pmode)
      MODE_EVEN: parity_of = xr;
      MODE_ODD:  parity_of = ~xr;
      MODE_MARK: parity_of = 1'b1;
      default:   parity_of = 1'b0;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      par_bit <= 1'b0;
    else if (Data_Valid)
      par_bit <= parity_of(PAR_TYP, ^P_DATA);
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             acc;
  logic [1:0]       mode;

  assign cnt_inc  = bit_cnt + CNT_W'(1);
  assign chk_busy = (state != IDLE);

  // rx_start outranks everything, so an abort never raises par_err
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      bit_cnt <= '0;
      acc     <= 1'b0;
      mode    <= 2'b00;
      par_err <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (rx_start) begin
        state   <= ACCUM;
        bit_cnt <= '0;
        acc     <= 1'b0;
        mode    <= PAR_TYP;
      end else begin
        case (state)
          ACCUM: begin
            if (rx_bit_vld) begin
              acc     <= acc ^ rx_bit;
              bit_cnt <= cnt_inc;
              if (cnt_inc == LAST_CNT)
                state <= WAIT_PAR;
            end
          end
          WAIT_PAR: begin
            if (rx_par_vld) begin
              par_err <= (rx_bit != parity_of(mode, acc));
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      err_count <= '0;
    else if (err_clr)
      err_count <= '0;
    else if (par_err && (err_count != {ERR_CNT_W{1'b1}}))
      err_count <= err_count + ERR_CNT_W'(1);
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_parity_engine.sv
// ============================================================================
// tb_parity_engine: randomized scoreboard bench for parity_engine.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_parity_engine;

  localparam int DW     = 8;
  localparam int ECW    = 8;
  localparam int EC_MAX = (1 << ECW) - 1;
`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [DW-1:0]  P_DATA = '0;
  logic           Data_Valid = 1'b0;
  logic [1:0]     PAR_TYP = 2'b00;
  logic           par_bit;
  logic           rx_start = 1'b0;
  logic           rx_bit = 1'b0;
  logic           rx_bit_vld = 1'b0;
  logic           rx_par_vld = 1'b0;
  logic           chk_busy;
  logic           par_err;
  logic           err_clr = 1'b0;
  logic [ECW-1:0] err_count;

  parity_engine #(.DATA_WIDTH(DW), .ERR_CNT_W(ECW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_TYP(PAR_TYP), .par_bit(par_bit), .rx_start(rx_start),
    .rx_bit(rx_bit), .rx_bit_vld(rx_bit_vld), .rx_par_vld(rx_par_vld),
    .chk_busy(chk_busy), .par_err(par_err), .err_clr(err_clr),
    .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic pb;
    logic err;
    logic busy;
    int   ec;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rnd     = 1'b0;

  // reference model: a frame is just the list of bits received so far
  bit       m_pb = 1'b0;
  bit       m_err = 1'b0;
  bit       m_active = 1'b0;
  bit [1:0] m_mode = 2'b00;
  int       m_ec = 0;
  bit       frame_bits[$];

  function automatic bit rule(input logic [1:0] pmode, input int ones);
    case (pmode)
      2'b00:   return (ones % 2) == 1;
      2'b01:   return (ones % 2) == 0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ones_in_word(input logic [DW-1:0] w);
    int n = 0;
    for (int i = 0; i < DW; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  task automatic model_update();
    exp_t e;
    bit   new_err;
    int   ones;
    if (!RST) begin
      m_pb = 1'b0; m_err = 1'b0; m_active = 1'b0; m_mode = 2'b00; m_ec = 0;
      frame_bits.delete();
    end else begin
      if (CNT_EN) begin
        if (err_clr) m_ec = 0;
        else if (m_err && m_ec < EC_MAX) m_ec = m_ec + 1;
      end
      new_err = 1'b0;
      if (Data_Valid) m_pb = rule(PAR_TYP, ones_in_word(P_DATA));
      if (rx_start) begin
        m_active = 1'b1;
        m_mode   = PAR_TYP;
        frame_bits.delete();
      end else if (m_active) begin
        if (frame_bits.size() < DW) begin
          if (rx_bit_vld) frame_bits.push_back(rx_bit);
        end else if (rx_par_vld) begin
          ones = 0;
          foreach (frame_bits[k]) ones += int'(frame_bits[k]);
          new_err  = (rx_bit != rule(m_mode, ones));
          m_active = 1'b0;
        end
      end
      m_err = new_err;
    end
    e.pb = m_pb; e.err = m_err; e.busy = m_active; e.ec = m_ec;
    exp_q.push_back(e);
  endtask

  task automatic step();
    if (rnd) begin
      Data_Valid = 1'($urandom);
      P_DATA     = DW'($urandom);
      if (!rx_start) PAR_TYP = 2'($urandom);
      err_clr    = ($urandom_range(0, 15) == 0);
    end
    model_update();
    @(posedge CLK);
    @(negedge CLK);
    Data_Valid = 1'b0; rx_start = 1'b0; rx_bit_vld = 1'b0;
    rx_par_vld = 1'b0; err_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] pmode, input logic [15:0] data,
                            input int nbits, input logic pbit, input bit do_par);
    rx_start = 1'b1;
    PAR_TYP  = pmode;
    step();
    for (int i = 0; i < nbits; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        rx_par_vld = 1'b1; rx_bit = 1'($urandom); step();
      end
      rx_bit = data[i]; rx_bit_vld = 1'b1; step();
    end
    if (do_par) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        rx_bit_vld = 1'b1; rx_bit = 1'($urandom); step();
      end
      rx_bit = pbit; rx_par_vld = 1'b1; step();
    end
  endtask

  // monitor: every cycle the DUT presents its outputs, compare with the model
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("par_bit",   32'(par_bit),   32'(e.pb));
        check("par_err",   32'(par_err),   32'(e.err));
        check("chk_busy",  32'(chk_busy),  32'(e.busy));
        check("err_count", 32'(err_count), 32'(e.ec));
      end
    end
  end

  initial begin
    logic [3:0] gen_exp;
    logic [15:0] d;
    bit good;
    gen_exp = 4'b0101;

    RST = 1'b0;
    repeat (3) step();
    RST = 1'b1;
    step();

    for (int m = 0; m < 4; m++) begin
      P_DATA = 8'hA7; PAR_TYP = 2'(m); Data_Valid = 1'b1;
      step();
      check("gen_A7", 32'(par_bit), 32'(gen_exp[m]));
    end
    PAR_TYP = 2'b01; P_DATA = 8'h00;
    step();
    check("gen_hold", 32'(par_bit), 32'd0);

    send_frame(2'b01, 16'h000F, DW, 1'b1, 1'b1);
    check("good_frame_err", 32'(par_err), 32'd0);
    step();
    check("good_frame_cnt", 32'(err_count), 32'd0);

    send_frame(2'b01, 16'h000F, DW, 1'b0, 1'b1);
    check("bad_frame_err", 32'(par_err), 32'd1);
    step();
    check("bad_frame_cnt", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);

    repeat (2) begin
      send_frame(2'b01, 16'h000F, DW, 1'b0, 1'b1);
      step();
    end
    check("cnt_three", 32'(err_count), CNT_EN ? 32'd3 : 32'd0);
    send_frame(2'b01, 16'h000F, DW, 1'b0, 1'b1);
    err_clr = 1'b1;
    step();
    check("clr_priority", 32'(err_count), 32'd0);

    send_frame(2'b01, 16'h000F, 4, 1'b0, 1'b0);
    send_frame(2'b01, 16'h000F, DW, 1'b1, 1'b1);
    check("abort_no_err", 32'(par_err), 32'd0);
    rx_bit_vld = 1'b1; rx_bit = 1'b1;
    send_frame(2'b01, 16'h000F, DW, 1'b1, 1'b1);
    check("start_wins_bit", 32'(par_err), 32'd0);

    send_frame(2'b00, 16'h00FF, 5, 1'b0, 1'b0);
    RST = 1'b0;
    repeat (2) step();
    RST = 1'b1;
    step();
    check("rst_busy", 32'(chk_busy), 32'd0);
    check("rst_cnt",  32'(err_count), 32'd0);
    check("rst_pbit", 32'(par_bit), 32'd0);
    rx_bit_vld = 1'b1; rx_bit = 1'b1; step();
    rx_par_vld = 1'b1; rx_bit = 1'b0; step();
    check("par_no_start", 32'(par_err), 32'd0);

    repeat (300) send_frame(2'b01, 16'h000F, DW, 1'b0, 1'b1);
    step();
    check("saturate", 32'(err_count), CNT_EN ? 32'(EC_MAX) : 32'd0);

    rnd = 1'b1;
    repeat (200) begin
      d    = 16'($urandom);
      good = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 5) == 0)
        send_frame(2'($urandom), d, $urandom_range(0, DW - 1), 1'b0, 1'b0);
      else
        send_frame(2'($urandom), d, DW, 1'($urandom), 1'b1);
      if (good) step();
    end
    rnd = 1'b0;

    repeat (3) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
